// File: rtl/autofire_pkg.sv
// autofire_pkg
//   Shared types and widths for the autofire key conditioner.
//   keyin_state_t : key FSM states (DELAY/REPEAT only reachable when
//                   AUTOFIRE_KEYIN_REPEAT_EN is defined, HELD only when it
//                   is not).
//   dir_t         : which key the FSM has latched as the active one.
package autofire_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    REPEAT = 3'd2,
    HELD   = 3'd3,
    LOCK   = 3'd4
  } keyin_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int PRESC_W = 16;
  localparam int DEB_W   = 8;
  localparam int RPT_W   = 10;

endpackage

// File: rtl/autofire_key_debounce.sv
// autofire_key_debounce
//   Two-flop synchroniser plus tick-based debouncer for one raw active-low key.
//   Ports:
//     clk21m  in  system clock
//     reset_n in  asynchronous reset, active low
//     tick    in  one-cycle time-base strobe (count_en)
//     raw_n   in  raw key pin, asynchronous, active low
//     pressed out debounced key state, 1 = pressed
//   The stable level changes only after DEB_TICKS consecutive ticks on which
//   the synchronised level differs from it.
module autofire_key_debounce
  import autofire_pkg::*;
#(
  parameter int DEB_TICKS = 8
) (
  input  logic clk21m,
  input  logic reset_n,
  input  logic tick,
  input  logic raw_n,
  output logic pressed
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

  logic [1:0]       sync_q;
  logic             stable_n;
  logic [DEB_W-1:0] deb_cnt;
  logic             sync_n;
  logic             differ;
  logic             accept;

  assign sync_n = sync_q[1];
  assign differ = (sync_n != stable_n);
  assign accept = tick && differ && (deb_cnt == DEB_LAST);

  // Synchroniser resets to "released" so a key held through reset is seen
  // as a fresh edge and must be debounced again.
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw_n};
    end
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      stable_n <= 1'b1;
      deb_cnt  <= '0;
    end else if (!differ) begin
      deb_cnt <= '0;
    end else if (accept) begin
      stable_n <= sync_n;
      deb_cnt  <= '0;
    end else if (tick) begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // On the accepting tick the new level is presented straight away, so the
  // key FSM acts on the same tick that completes the debounce.
  assign pressed = accept ? ~sync_n : ~stable_n;

endmodule

// File: rtl/autofire_keyin.sv
// autofire_keyin
//   Upstream conditioner for the autofire speed controller. Produces the
//   count_en time base and converts two raw active-low speed keys into
//   single-cycle af_increment / af_decriment requests with typematic repeat.
//   Ports:
//     clk21m       in  system clock (21.477 MHz)
//     reset_n      in  asynchronous reset, active low
//     key_up_n     in  raw speed-up key, active low
//     key_down_n   in  raw speed-down key, active low
//     count_en     out one-cycle tick every PRESCALE clocks
//     af_increment out one-cycle speed-up request
//     af_decriment out one-cycle speed-down request
//   Build option: define AUTOFIRE_KEYIN_REPEAT_EN for auto-repeat
//   (DELAY/REPEAT states and rpt_cnt). Without it each press gives exactly
//   one pulse and the FSM waits in HELD until release.
module autofire_keyin
  import autofire_pkg::*;
#(
  parameter int PRESCALE     = 21477,
  parameter int DEB_TICKS    = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk21m,
  input  logic reset_n,
  input  logic key_up_n,
  input  logic key_down_n,
  output logic count_en,
  output logic af_increment,
  output logic af_decriment
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  // ---------------------------------------------------------------- prescaler
  logic [PRESC_W-1:0] presc_cnt;

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (presc_cnt == PRESC_LAST) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // Decoded from a register, so it is clean and is 0 throughout reset.
  assign count_en = (presc_cnt == PRESC_LAST);

  // ----------------------------------------------------------------- debounce
  logic up_pressed;
  logic dn_pressed;

  autofire_key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_up (
    .clk21m  (clk21m),
    .reset_n (reset_n),
    .tick    (count_en),
    .raw_n   (key_up_n),
    .pressed (up_pressed)
  );

  autofire_key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_down (
    .clk21m  (clk21m),
    .reset_n (reset_n),
    .tick    (count_en),
    .raw_n   (key_down_n),
    .pressed (dn_pressed)
  );

  // ---------------------------------------------------------------------- FSM
  keyin_state_t state_q, state_nxt;
  dir_t         dir_q, dir_nxt;
  logic         inc_nxt, dec_nxt;
  logic         held_key, other_key;

`ifdef AUTOFIRE_KEYIN_REPEAT_EN
  logic [RPT_W-1:0] rpt_cnt, rpt_nxt;
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  assign held_key  = (dir_q == DIR_UP) ? up_pressed : dn_pressed;
  assign other_key = (dir_q == DIR_UP) ? dn_pressed : up_pressed;

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dir_q        <= DIR_UP;
      af_increment <= 1'b0;
      af_decriment <= 1'b0;
`ifdef AUTOFIRE_KEYIN_REPEAT_EN
      rpt_cnt      <= '0;
`endif
    end else begin
      state_q      <= state_nxt;
      dir_q        <= dir_nxt;
      af_increment <= inc_nxt;
      af_decriment <= dec_nxt;
`ifdef AUTOFIRE_KEYIN_REPEAT_EN
      rpt_cnt      <= rpt_nxt;
`endif
    end
  end

  // Pulses are only requested on count_en cycles and registered, so they
  // land in the cycle after the tick and can never overlap count_en
  // (PRESCALE >= 2).
  always_comb begin
    state_nxt = state_q;
    dir_nxt   = dir_q;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
`ifdef AUTOFIRE_KEYIN_REPEAT_EN
    rpt_nxt   = rpt_cnt;
`endif
    if (count_en) begin
      unique case (state_q)
        IDLE: begin
          if (up_pressed && dn_pressed) begin
            state_nxt = LOCK;
          end else if (up_pressed || dn_pressed) begin
            dir_nxt = up_pressed ? DIR_UP : DIR_DOWN;
            inc_nxt = up_pressed;
            dec_nxt = dn_pressed;
`ifdef AUTOFIRE_KEYIN_REPEAT_EN
            rpt_nxt   = RPT_W'(REPEAT_DELAY);
            state_nxt = DELAY;
`else
            state_nxt = HELD;
`endif
          end
        end
`ifdef AUTOFIRE_KEYIN_REPEAT_EN
        // Release is checked before the countdown, so a key let go on the
        // tick that would have repeated produces no pulse.
        DELAY, REPEAT: begin
          if (!held_key) begin
            state_nxt = IDLE;
          end else if (other_key) begin
            state_nxt = LOCK;
          end else if (rpt_cnt == RPT_W'(1)) begin
            inc_nxt   = (dir_q == DIR_UP);
            dec_nxt   = (dir_q == DIR_DOWN);
            rpt_nxt   = RPT_W'(REPEAT_RATE);
            state_nxt = REPEAT;
          end else begin
            rpt_nxt = rpt_cnt - 1'b1;
          end
        end
`else
        HELD: begin
          if (!held_key) begin
            state_nxt = IDLE;
          end else if (other_key) begin
            state_nxt = LOCK;
          end
        end
`endif
        LOCK: begin
          if (!up_pressed && !dn_pressed) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_autofire_keyin.sv
// tb_autofire_keyin
//   Directed bench for autofire_keyin with PRESCALE=4, DEB_TICKS=3,
//   REPEAT_DELAY=5, REPEAT_RATE=2. Expected pulse positions are given as the
//   tick edge (clock edges counted from reset release) that produced them.
//   Expectations follow AUTOFIRE_KEYIN_REPEAT_EN when it is defined.
module tb_autofire_keyin;

  // ------------------------------------------------------ clock / reset block
  logic clk21m     = 1'b0;
  logic reset_n    = 1'b0;
  logic key_up_n   = 1'b1;
  logic key_down_n = 1'b1;
  logic count_en;
  logic af_increment;
  logic af_decriment;

  always #5 clk21m = ~clk21m;

  autofire_keyin #(
    .PRESCALE     (4),
    .DEB_TICKS    (3),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clk21m       (clk21m),
    .reset_n      (reset_n),
    .key_up_n     (key_up_n),
    .key_down_n   (key_down_n),
    .count_en     (count_en),
    .af_increment (af_increment),
    .af_decriment (af_decriment)
  );

  // Edges since the last reset release.
  int cyc = 0;
  always @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // ------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  int ce_q[$];
  int inc_q[$];
  int dec_q[$];
  logic [15:0] exp_q[$];
  logic prev_inc = 1'b0;
  logic prev_dec = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor samples on the falling edge; pulses are logged by the tick edge
  // that produced them, count_en by the edge that will consume it.
  always @(negedge clk21m) begin
    if (count_en)     ce_q.push_back(cyc + 1);
    if (af_increment) inc_q.push_back(cyc);
    if (af_decriment) dec_q.push_back(cyc);
    if (af_increment && af_decriment) viol++;
    if ((af_increment || af_decriment) && count_en) viol++;
    if ((af_increment && prev_inc) || (af_decriment && prev_dec)) viol++;
    prev_inc = af_increment;
    prev_dec = af_decriment;
  end

  task automatic clear_logs();
    ce_q.delete();
    inc_q.delete();
    dec_q.delete();
  endtask

  task automatic check_log(input string tag, input bit use_inc);
    int n;
    n = use_inc ? inc_q.size() : dec_q.size();
    check($sformatf("%s_count", tag), n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_%0d", tag, i), use_inc ? inc_q[i] : dec_q[i], 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // ----------------------------------------------------------- driver tasks
  // Inputs change 2 time units after a rising edge.
  task automatic goto_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 5000) begin
      @(posedge clk21m);
      #2;
      guard++;
    end
    check($sformatf("goto_%0d", target), cyc, target);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(posedge clk21m);
    #1;
    check("rst_count_en", count_en, 0);
    check("rst_inc", af_increment, 0);
    check("rst_dec", af_decriment, 0);
    #1;
    reset_n = 1'b1;
    clear_logs();

    // Idle: ticks on 4, 8, 12 ... and no requests.
    goto_cyc(200);
    check("idle_ce_total", ce_q.size(), 50);
    check("idle_ce_0", ce_q[0], 4);
    check("idle_ce_1", ce_q[1], 8);
    check("idle_ce_2", ce_q[2], 12);
    check("idle_inc", inc_q.size(), 0);
    check("idle_dec", dec_q.size(), 0);

    // Hold down for 60 cycles.
    clear_logs();
    key_down_n = 1'b0;
    goto_cyc(260);
    key_down_n = 1'b1;
    goto_cyc(300);
`ifdef AUTOFIRE_KEYIN_REPEAT_EN
    exp_q = '{16'd212, 16'd232, 16'd240, 16'd248, 16'd256, 16'd264};
`else
    exp_q = '{16'd212};
`endif
    check_log("hold_dn", 1'b0);
    check("hold_dn_inc", inc_q.size(), 0);

    // Up glitch of two ticks.
    clear_logs();
    key_up_n = 1'b0;
    goto_cyc(308);
    key_up_n = 1'b1;
    goto_cyc(340);
    check("glitch_inc", inc_q.size(), 0);
    check("glitch_dec", dec_q.size(), 0);

    // Up held, down joins -> LOCK until both released, then a fresh press.
    clear_logs();
    key_up_n = 1'b0;
    goto_cyc(352);
    key_down_n = 1'b0;
    goto_cyc(400);
    key_up_n = 1'b1;
    goto_cyc(420);
    key_down_n = 1'b1;
    goto_cyc(440);
    key_up_n = 1'b0;
    goto_cyc(460);
    key_up_n = 1'b1;
    goto_cyc(500);
    exp_q = '{16'd352, 16'd452};
    check_log("lock_up", 1'b1);
    check("lock_dec", dec_q.size(), 0);

    // Reset while repeating with down held.
    clear_logs();
    key_down_n = 1'b0;
    goto_cyc(540);
`ifdef AUTOFIRE_KEYIN_REPEAT_EN
    check("pre_rst_pulse", af_decriment, 1);
    exp_q = '{16'd512, 16'd532};
`else
    check("pre_rst_pulse", af_decriment, 0);
    exp_q = '{16'd512};
`endif
    reset_n = 1'b0;
    #1;
    check("mid_rst_dec", af_decriment, 0);
    check("mid_rst_inc", af_increment, 0);
    check("mid_rst_ce", count_en, 0);
    check_log("pre_rst", 1'b0);
    clear_logs();
    repeat (3) @(posedge clk21m);
    #2;
    reset_n = 1'b1;
    goto_cyc(16);
    key_down_n = 1'b1;
    goto_cyc(40);
    check("post_rst_ce_0", ce_q.size() > 0 ? ce_q[0] : -1, 4);
    exp_q = '{16'd12};
    check_log("post_rst", 1'b0);
    check("post_rst_inc", inc_q.size(), 0);

    // Hold up for 100 cycles.
    clear_logs();
    key_up_n = 1'b0;
    goto_cyc(140);
    key_up_n = 1'b1;
    goto_cyc(200);
`ifdef AUTOFIRE_KEYIN_REPEAT_EN
    exp_q = '{16'd52, 16'd72, 16'd80, 16'd88, 16'd96, 16'd104,
              16'd112, 16'd120, 16'd128, 16'd136, 16'd144};
`else
    exp_q = '{16'd52};
`endif
    check_log("hold_up", 1'b1);
    check("hold_up_dec", dec_q.size(), 0);

    check("output_rules", viol, 0);

    // -------------------------------------------------------------- report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
